// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Instructions are two bytes, hi byte first, on a 12-bit byte address space.
package fetch_pkg;

  typedef logic [7:0]  u8;
  typedef logic [11:0] u12;
  typedef logic [15:0] u16;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2,
    DRAIN    = 2'd3
  } fetch_state_t;

  localparam u12 PROGRAM_START = 12'h200;

  // Address arithmetic wraps modulo 4 KiB.
  function automatic u12 addr_add(input u12 base, input u12 offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/fetch.sv
// Two-byte instruction fetcher: reads hi then lo byte, holds the word for decode,
// and on redirect discards partial work, draining any read still in flight.
module fetch
  import fetch_pkg::*;
#(
  parameter u12 RESET_PC = PROGRAM_START
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [11:0] pc,
  input  logic        redirect,
  input  logic [11:0] redirect_pc
);

  fetch_state_t state_q;
  u12           pc_q;
  u16           instr_q;
  logic         instr_valid_q;
  logic         mem_req_q;
  u12           mem_addr_q;

  // A response only counts while our own request is up; this also masks
  // late responses to a read that a reset aborted.
  logic rsp_ok;
  assign rsp_ok = mem_req_q & mem_valid;

  // NOTE: reset is asynchronous and active-low, so it sits in the sensitivity
  // list; all state updates use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH_HI;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_PC;
    end else if (redirect) begin
      pc_q          <= redirect_pc;
      instr_valid_q <= 1'b0;
      if (mem_req_q && !mem_valid) begin
        // A read is in flight: keep its address up until it completes.
        state_q <= DRAIN;
      end else begin
        state_q    <= FETCH_HI;
        mem_req_q  <= 1'b1;
        mem_addr_q <= redirect_pc;
      end
    end else begin
      unique case (state_q)
        FETCH_HI: begin
          // Raises the request on the first cycle out of reset.
          mem_req_q <= 1'b1;
          if (rsp_ok) begin
            instr_q[15:8] <= mem_rdata;
            mem_addr_q    <= addr_add(pc_q, 12'd1);
            state_q       <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (rsp_ok) begin
            instr_q[7:0]  <= mem_rdata;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc_q          <= addr_add(pc_q, 12'd2);
            mem_addr_q    <= addr_add(pc_q, 12'd2);
            mem_req_q     <= 1'b1;
            instr_valid_q <= 1'b0;
            state_q       <= FETCH_HI;
          end
        end
        DRAIN: begin
          if (rsp_ok) begin
            mem_addr_q <= pc_q;
            state_q    <= FETCH_HI;
          end
        end
        default: state_q <= FETCH_HI;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: zero-wait fetch, backpressure, wrap, drain,
// redirect-vs-accept priority and mid-fetch reset, against a latency-programmable memory.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] pc;
  logic        redirect;
  logic [11:0] redirect_pc;

  int n_checks;
  int n_errors;

  logic [7:0] mem [4096];
  int         lat;
  int         wait_cnt;
  logic       force_valid;

  fetch #(.RESET_PC(12'h200)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc         (pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers once the request has been up for lat cycles (0 = same cycle).
  assign mem_rdata = mem[mem_addr];
  assign mem_valid = force_valid | (mem_req && (wait_cnt >= lat));

  always @(posedge clk or negedge rst) begin
    if (!rst)                     wait_cnt <= 0;
    else if (mem_valid || !mem_req) wait_cnt <= 0;
    else                          wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit drained;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'h202] = 8'h56; mem[12'h203] = 8'h78;
    mem[12'hFFF] = 8'hAB; mem[12'h000] = 8'hCD;
    mem[12'h300] = 8'h9A; mem[12'h301] = 8'hBC;
    mem[12'h250] = 8'hDE; mem[12'h251] = 8'hF0;

    rst = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    lat = 0; force_valid = 1'b0;
    n_checks = 0; n_errors = 0;

    // Reset values
    step(); step();
    check("rst_req",   {15'd0, mem_req}, 16'd0);
    check("rst_addr",  {4'd0, mem_addr}, 16'h200);
    check("rst_pc",    {4'd0, pc}, 16'h200);
    check("rst_instr", instr, 16'h0000);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    rst = 1'b1;

    // Zero-wait fetch of 0x1234
    step();
    check("c0_req",  {15'd0, mem_req}, 16'd1);
    check("c0_addr", {4'd0, mem_addr}, 16'h200);
    step();
    check("c1_addr",  {4'd0, mem_addr}, 16'h201);
    check("c1_valid", {15'd0, instr_valid}, 16'd0);
    step();
    check("c2_valid", {15'd0, instr_valid}, 16'd1);
    check("c2_instr", instr, 16'h1234);
    check("c2_pc",    {4'd0, pc}, 16'h200);
    check("c2_req",   {15'd0, mem_req}, 16'd0);
    step();
    check("c3_addr", {4'd0, mem_addr}, 16'h202);
    check("c3_pc",   {4'd0, pc}, 16'h202);

    // Backpressure on 0x5678
    instr_ready = 1'b0;
    step(); step();
    check("bp_valid", {15'd0, instr_valid}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_instr", instr, 16'h5678);
      check("bp_pc",    {4'd0, pc}, 16'h202);
      check("bp_req",   {15'd0, mem_req}, 16'd0);
    end
    instr_ready = 1'b1;
    step();
    check("bp_next_addr", {4'd0, mem_addr}, 16'h204);
    check("bp_next_pc",   {4'd0, pc}, 16'h204);

    // Redirect to 0xFFF with a same-cycle response, then wrap
    redirect = 1'b1; redirect_pc = 12'hFFF;
    step();
    redirect = 1'b0;
    check("wr_addr_hi", {4'd0, mem_addr}, 16'hFFF);
    check("wr_pc",      {4'd0, pc}, 16'hFFF);
    step();
    check("wr_addr_lo", {4'd0, mem_addr}, 16'h000);
    step();
    check("wr_instr", instr, 16'hABCD);
    check("wr_valid", {15'd0, instr_valid}, 16'd1);
    step();
    check("wr_next_addr", {4'd0, mem_addr}, 16'h001);
    check("wr_next_pc",   {4'd0, pc}, 16'h001);

    // Redirect during FETCH_LO with a slow response -> drain
    step();
    check("dr_lo_addr", {4'd0, mem_addr}, 16'h002);
    lat = 3;
    redirect = 1'b1; redirect_pc = 12'h300;
    step();
    redirect = 1'b0;
    check("dr_pc", {4'd0, pc}, 16'h300);
    drained = 1'b0;
    for (int i = 0; i < 10 && !drained; i++) begin
      check("dr_valid", {15'd0, instr_valid}, 16'd0);
      check("dr_addr",  {4'd0, mem_addr}, 16'h002);
      check("dr_req",   {15'd0, mem_req}, 16'd1);
      if (mem_valid) begin
        drained = 1'b1;
        lat = 0;
      end
      step();
    end
    check("dr_timeout", {15'd0, drained}, 16'd1);
    check("dr_new_addr",  {4'd0, mem_addr}, 16'h300);
    check("dr_new_valid", {15'd0, instr_valid}, 16'd0);
    step();
    check("dr_lo_new", {4'd0, mem_addr}, 16'h301);
    step();
    check("dr_instr", instr, 16'h9ABC);
    check("dr_ipc",   {4'd0, pc}, 16'h300);

    // Redirect and accept in the same HOLD cycle: redirect wins
    redirect = 1'b1; redirect_pc = 12'h250;
    step();
    redirect = 1'b0;
    check("ra_addr",  {4'd0, mem_addr}, 16'h250);
    check("ra_pc",    {4'd0, pc}, 16'h250);
    check("ra_valid", {15'd0, instr_valid}, 16'd0);
    step();
    check("ra_lo_addr", {4'd0, mem_addr}, 16'h251);

    // Reset mid-FETCH_LO, with a stale response arriving while mem_req is low
    #2 rst = 1'b0;
    #1;
    check("ar_req",   {15'd0, mem_req}, 16'd0);
    check("ar_addr",  {4'd0, mem_addr}, 16'h200);
    check("ar_pc",    {4'd0, pc}, 16'h200);
    check("ar_instr", instr, 16'h0000);
    force_valid = 1'b1;
    step();
    rst = 1'b1;
    step();
    force_valid = 1'b0;
    check("ar_restart_req",  {15'd0, mem_req}, 16'd1);
    check("ar_restart_addr", {4'd0, mem_addr}, 16'h200);
    step();
    check("ar_lo_addr", {4'd0, mem_addr}, 16'h201);
    step();
    check("ar_instr2", instr, 16'h1234);
    check("ar_valid2", {15'd0, instr_valid}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
